// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: two-stage carry-lookahead subtractor, diff = a - b - bin.
// Stage 1 resolves the low half, stage 2 the high half, with valid/ready on both sides.
module cla_sub_pipe #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);
    localparam int H = N / 2;

    // Each carry is a flat sum of generate/propagate products, not a ripple.
    function automatic logic [H:0] cla(
        input logic [H-1:0] g,
        input logic [H-1:0] p,
        input logic         c0
    );
        logic [H:0] c;
        logic       t;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < H; i++) begin
            t = c0;
            for (int j = 0; j <= i; j++) t = t & p[j];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int k = j + 1; k <= i; k++) t = t & p[k];
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

    logic         s1_valid_q, s1_valid_d;
    logic [H-1:0] s1_dlo_q, s1_dlo_d;
    logic         s1_c_q, s1_c_d;
    logic [H-1:0] s1_ahi_q, s1_ahi_d;
    logic [H-1:0] s1_nbhi_q, s1_nbhi_d;
    logic         s2_valid_q, s2_valid_d;
    logic [N-1:0] diff_q, diff_d;
    logic         bout_q, bout_d;
    logic         ovf_q, ovf_d;

    logic [H-1:0] g1, p1, g2, p2;
    logic [H:0]   c1, c2;
    logic         s2_adv, in_fire;

    assign p1 = a[H-1:0] ^ ~b[H-1:0];
    assign g1 = a[H-1:0] & ~b[H-1:0];
    assign c1 = cla(g1, p1, ~bin);

    assign p2 = s1_ahi_q ^ s1_nbhi_q;
    assign g2 = s1_ahi_q & s1_nbhi_q;
    assign c2 = cla(g2, p2, s1_c_q);

    assign s2_adv    = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready  = ~s1_valid_q | s2_adv;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_dlo_d   = s1_dlo_q;
        s1_c_d     = s1_c_q;
        s1_ahi_d   = s1_ahi_q;
        s1_nbhi_d  = s1_nbhi_q;
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_dlo_d   = p1 ^ c1[H-1:0];
            s1_c_d     = c1[H];
            s1_ahi_d   = a[N-1:H];
            s1_nbhi_d  = ~b[N-1:H];
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s2_adv) begin
            s2_valid_d = 1'b1;
            diff_d     = {p2 ^ c2[H-1:0], s1_dlo_q};
            // Subtraction borrows when the final carry is absent.
            bout_d     = ~c2[H];
            ovf_d      = c2[H] ^ c2[H-1];
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_dlo_q   <= '0;
            s1_c_q     <= 1'b0;
            s1_ahi_q   <= '0;
            s1_nbhi_q  <= '0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_dlo_q   <= s1_dlo_d;
            s1_c_q     <= s1_c_d;
            s1_ahi_q   <= s1_ahi_d;
            s1_nbhi_q  <= s1_nbhi_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_cla_sub_pipe.sv
// tb_cla_sub_pipe: directed and streamed checks of cla_sub_pipe (N=16)
// against an arithmetic reference queue.
module tb_cla_sub_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    exp_t q[$];

    cla_sub_pipe #(.N(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic c);
        exp_t m;
        int   ur, sr;
        ur   = int'(x) - int'(y) - int'(c);
        sr   = int'($signed(x)) - int'($signed(y)) - int'(c);
        m.d  = ur[15:0];
        m.bo = (ur < 0);
        m.ov = (sr < -32768) || (sr > 32767);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference check on every meaningful cycle, sampled mid-period.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious: out_valid=1 diff=0x%0h with nothing in flight", diff);
                end else if ({diff, bout, ovf} !== {q[0].d, q[0].bo, q[0].ov}) begin
                    fails++;
                    $display("FAIL model: got d=%h bo=%b ov=%b expected d=%h bo=%b ov=%b",
                             diff, bout, ovf, q[0].d, q[0].bo, q[0].ov);
                end
                if (out_ready && q.size() != 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, bin));
                tests++;
                if (q.size() > 2) begin
                    fails++;
                    $display("FAIL inflight: got %0d expected <=2", q.size());
                end
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic c, output int waits);
        logic acc;
        waits = 0;
        in_valid = 1'b1; a = x; b = y; bin = c;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            waits++;
        end while (!acc && waits < 50);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic op1(input string name, input logic [15:0] x,
                       input logic [15:0] y, input logic c,
                       input logic [15:0] ed, input logic eb, input logic eo);
        int w;
        @(posedge clk); #1;
        chk({name, "_rdy"}, 32'(in_ready), 32'd1);
        send(x, y, c, w);
        chk({name, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({name, "_lat2"}, 32'(out_valid), 32'd1);
        chk({name, "_diff"}, 32'(diff), 32'(ed));
        chk({name, "_bout"}, 32'(bout), 32'(eb));
        chk({name, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drained"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        int w, stalls, acc;
        logic [15:0] held;

        #1;
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_irdy", 32'(in_ready), 32'd1);

        op1("t1", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        op1("t2a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        op1("t2b", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        op1("t3a", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);
        op1("t3b", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        op1("t3c", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        op1("t3d", 16'h00FF, 16'h00FF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        drain("t3");

        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), w);
            if (w != 1) stalls++;
        end
        chk("t4_stalls", 32'(stalls), 32'd0);
        drain("t4");

        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 16'h1234; b = 16'h0034; bin = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
            if (acc == 1) begin a = 16'h0001; b = 16'h0002; bin = 1'b1; end
            if (acc == 2) begin a = 16'hAAAA; b = 16'h5555; bin = 1'b0; end
            if (i == 2) held = diff;
        end
        chk("t5_accepts", 32'(acc), 32'd2);
        chk("t5_irdy", 32'(in_ready), 32'd0);
        chk("t5_ovalid", 32'(out_valid), 32'd1);
        chk("t5_stable", 32'(diff), 32'(held));
        chk("t5_head", 32'(diff), 32'h1200);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t5_second", 32'(diff), 32'hFFFE);
        drain("t5");

        out_ready = 1'b0;
        send(16'h4444, 16'h1111, 1'b0, w);
        send(16'h2222, 16'h1111, 1'b0, w);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_ovalid", 32'(out_valid), 32'd0);
        chk("t6_diff", 32'(diff), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_irdy", 32'(in_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_noresult", 32'(out_valid), 32'd0);
        op1("t6_after", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        drain("end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
